// File: rtl/phys_ram_responder.sv
// Byte-addressed little-endian RAM model for the MemoryController physical port.
// Requests are handled by an IDLE/WAIT/DONE sequencer with configurable latency and range checking.
module phys_ram_responder #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BITS  = 16,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             phRamAddress,
    input  logic [8*DATA_BYTES-1:0] phRamWrite,
    input  logic [DATA_BYTES-1:0]   phByteEn,
    input  logic                    phReadReq,
    input  logic                    phWriteReq,
    output logic [8*DATA_BYTES-1:0] phRamRead,
    output logic                    phBusy,
    output logic                    phAck,
    output logic                    phError
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                 r_state, w_next;
    logic [3:0]             r_cnt, w_cnt_next;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DW-1:0]          r_wdata;
    logic [DATA_BYTES-1:0]  r_be;
    logic                   r_write;
    logic                   r_err;
    logic [7:0]             r_mem [DEPTH];

    logic                   w_req, w_accept, w_range_err, w_req_err, w_commit;
    logic [32:0]            w_last;

    assign w_req       = phReadReq | phWriteReq;
    assign w_accept    = (r_state == S_IDLE) && w_req;
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    assign w_last      = {1'b0, phRamAddress} + 33'(DATA_BYTES - 1);
    assign w_range_err = w_last >= (33'd1 << ADDR_BITS);
    assign w_req_err   = w_range_err | (phReadReq & phWriteReq);
    assign w_commit    = (r_state == S_DONE) && !r_err;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: if (w_req) begin
                w_cnt_next = 4'(LATENCY);
                w_next     = (LATENCY == 0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            phRamRead <= '0;
            phBusy    <= 1'b0;
            phAck     <= 1'b0;
            phError   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            phAck   <= 1'b0;
            phError <= 1'b0;
            if (w_accept) begin
                r_addr  <= phRamAddress[ADDR_BITS-1:0];
                r_wdata <= phRamWrite;
                r_be    <= phByteEn;
                r_write <= phWriteReq;
                r_err   <= w_req_err;
                phBusy  <= 1'b1;
            end
            if (r_state == S_DONE) begin
                phBusy  <= 1'b0;
                phAck   <= 1'b1;
                phError <= r_err;
                if (w_commit && !r_write)
                    for (int i = 0; i < DATA_BYTES; i++)
                        phRamRead[8*i +: 8] <= r_mem[r_addr + ADDR_BITS'(i)];
            end
        end
    end

    // Array has no reset so contents survive it; an aborted access never reaches DONE
    always_ff @(posedge clk) begin
        if (w_commit && r_write)
            for (int i = 0; i < DATA_BYTES; i++)
                if (r_be[i]) r_mem[r_addr + ADDR_BITS'(i)] <= r_wdata[8*i +: 8];
    end
endmodule

// File: doc/phys_ram_responder.md
Name: phys_ram_responder

Overview:
Parametrised, byte-addressed, little-endian physical RAM model that services the MemoryController physical port (phRamAddress/phRamWrite/phReadReq/phWriteReq/phRamRead). It generalises the single-cycle testbench RAM loop into a reusable block. It adds configurable data width, depth and access latency, per-byte write enables, an explicit busy/acknowledge handshake, and out-of-range error reporting. It is instantiated in MMU and CPU benches in place of inline fileRam logic.

Parameters:
DATA_BYTES, 4, bytes per access; phRamRead/phRamWrite width = 8*DATA_BYTES.
ADDR_BITS, 16, byte-array depth = 2**ADDR_BITS bytes.
LATENCY, 1, extra wait cycles between request acceptance and completion (0..15).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
phRamAddress  in  32  byte address of access (lowest byte, little-endian)
phRamWrite  in  8*DATA_BYTES  write data; byte i goes to address+i
phByteEn  in  DATA_BYTES  per-byte write enable; ignored for reads
phReadReq  in  1  read request, level
phWriteReq  in  1  write request, level
phRamRead  out  8*DATA_BYTES  read data; byte i from address+i
phBusy  out  1  high while an accepted request is in flight
phAck  out  1  one-cycle completion pulse
phError  out  1  valid with phAck; access rejected

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, wait counter 0, phRamRead=0, phBusy=0, phAck=0, phError=0. Memory contents are NOT cleared and survive reset.
- States: IDLE, WAIT, DONE.
- IDLE: on a rising edge with phReadReq|phWriteReq=1:
  - capture address, data, byte enables and op;
  - set phBusy=1;
  - load counter with LATENCY;
  - go to WAIT, or to DONE if LATENCY=0.
- WAIT: decrement counter each edge. Inputs are ignored. When counter reaches 1, go to DONE on the next edge.
- DONE transition (one edge): perform the access using captured values, assert phAck=1 for exactly one cycle, clear phBusy, return to IDLE.
- Latency: request sampled at edge N, phAck high after edge N+LATENCY+1. Minimum 1 cycle (LATENCY=0).
- Back-to-back: a request still held during the phAck cycle is accepted on the edge ending that cycle. With held requests, sustained throughput is one access per LATENCY+2 cycles.
- Read: phRamRead[8i+7:8i] = mem[addr+i]. Updates only at read completion; holds its value otherwise, including across writes.
- Write: mem[addr+i] = phRamWrite[8i+7:8i] only where phByteEn[i]=1. Commits on the DONE edge.
- Error (phError=1 with phAck, no memory change, phRamRead unchanged) in either case:
  - address+DATA_BYTES-1 >= 2**ADDR_BITS, evaluated in 33-bit arithmetic so there is no 32-bit wrap;
  - phReadReq and phWriteReq both 1 at acceptance.
- phError=0 on every other cycle.
- No address wrap-around inside the array. Unaligned addresses are legal.
- Reset mid-operation aborts the access: no memory write, no phAck.
- Request deasserted after acceptance has no effect; the access completes.

Test Plan:
- LATENCY=1: write 32'h00000123 to addr 0 with phByteEn=4'hF -> phAck 2 cycles after acceptance, mem[0..3]=23,01,00,00. Then read addr 0 -> phRamRead=32'h00000123, phError=0.
- Byte enables: write 32'hAABBCCDD at addr 8 with phByteEn=4'b0101 over prefilled 32'h11111111 -> read returns 32'h11BB11DD.
- Unaligned/boundary: read at addr 2**16-4 succeeds. Read at addr 2**16-3 -> phAck with phError=1 and phRamRead unchanged. Address 32'hFFFFFFFE -> error.
- Both phReadReq=1 and phWriteReq=1 -> phError=1, memory unchanged.
- Latency sweep LATENCY=0,3 with held phReadReq -> phAck every 2 and 5 cycles respectively; phBusy high exactly LATENCY+1 cycles per access.
- Drop reset to 0 in the WAIT state of a write to addr 16 -> outputs return to 0 immediately, no phAck. Subsequent read of addr 16 returns the old contents, and memory at 0 is still 32'h00000123.
